// File: rtl/regfile_sb.sv
// regfile_sb: DEPTH x WIDTH register file with a per-register busy scoreboard.
// Two combinational read ports, one synchronous writeback port, one issue
// (reserve) port and a registered population count of the busy bits.
// Optional build macro REGFILE_BYPASS_EN forwards the writeback data and
// the post-writeback busy state to the read ports in the Load cycle.
// Reset is synchronous and active-high.
module regfile_sb #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [AW-1:0]    DR_In,
  input  logic [WIDTH-1:0] In,
  input  logic             Issue,
  input  logic [AW-1:0]    Issue_DR,
  input  logic [AW-1:0]    SR1_In,
  input  logic [AW-1:0]    SR2_In,
  output logic [WIDTH-1:0] SR1_Out,
  output logic [WIDTH-1:0] SR2_Out,
  output logic             Busy1,
  output logic             Busy2,
  output logic [AW:0]      Busy_Cnt
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;

  // Next scoreboard state: writeback clears, issue sets; issue applied last so it dominates.
  always_comb begin
    busy_nxt = busy;
    if (Load)  busy_nxt[DR_In]    = 1'b0;
    if (Issue) busy_nxt[Issue_DR] = 1'b1;
  end

  // Population count of the next busy vector so Busy_Cnt lines up with the busy bits.
  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  // Register storage: cleared on reset, otherwise written by the writeback port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      data <= '{default: '0};
    end else if (Load) begin
      data[DR_In] <= In;
    end
  end

  // Scoreboard and busy count: reset discards all outstanding reservations.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy     <= '0;
      Busy_Cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      Busy_Cnt <= cnt_nxt;
    end
  end

  // Read ports: registered contents, optionally overridden by the in-flight writeback.
  always_comb begin
    SR1_Out = data[SR1_In];
    SR2_Out = data[SR2_In];
    Busy1   = busy[SR1_In];
    Busy2   = busy[SR2_In];
`ifdef REGFILE_BYPASS_EN
    if (Load && (SR1_In == DR_In)) begin
      SR1_Out = In;
      Busy1   = Issue && (Issue_DR == DR_In);
    end
    if (Load && (SR2_In == DR_In)) begin
      SR2_Out = In;
      Busy2   = Issue && (Issue_DR == DR_In);
    end
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb. Stimulus pushes the
// expected read-port / busy / count values for the current cycle into a
// queue; a monitor on the falling edge pops and compares. Two instances:
// default (16x8) and WIDTH=32, DEPTH=16.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic Clk;
  logic Reset;

  // Instance A: 16 x 8
  logic        Load, Issue;
  logic [2:0]  DR_In, Issue_DR, SR1_In, SR2_In;
  logic [15:0] In, SR1_Out, SR2_Out;
  logic        Busy1, Busy2;
  logic [3:0]  Busy_Cnt;

  // Instance B: 32 x 16
  logic        b_load, b_issue;
  logic [3:0]  b_dr, b_idr, b_sr1, b_sr2;
  logic [31:0] b_in, b_o1, b_o2;
  logic        b_busy1, b_busy2;
  logic [4:0]  b_cnt;

  regfile_sb dut_a (
    .Clk(Clk), .Reset(Reset), .Load(Load), .DR_In(DR_In), .In(In),
    .Issue(Issue), .Issue_DR(Issue_DR), .SR1_In(SR1_In), .SR2_In(SR2_In),
    .SR1_Out(SR1_Out), .SR2_Out(SR2_Out), .Busy1(Busy1), .Busy2(Busy2),
    .Busy_Cnt(Busy_Cnt)
  );

  regfile_sb #(.WIDTH(32), .DEPTH(16)) dut_b (
    .Clk(Clk), .Reset(Reset), .Load(b_load), .DR_In(b_dr), .In(b_in),
    .Issue(b_issue), .Issue_DR(b_idr), .SR1_In(b_sr1), .SR2_In(b_sr2),
    .SR1_Out(b_o1), .SR2_Out(b_o2), .Busy1(b_busy1), .Busy2(b_busy2),
    .Busy_Cnt(b_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc_n = 0;
  always @(posedge Clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int          cyc;
    string       name;
    bit          inst_b;
    logic [31:0] o1;
    logic [31:0] o2;
    logic        bu1;
    logic        bu2;
    logic [4:0]  cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input string name, input bit inst_b, input logic [31:0] o1,
                      input logic [31:0] o2, input logic bu1, input logic bu2,
                      input logic [4:0] cnt);
    exp_t e;
    e.cyc = cyc_n; e.name = name; e.inst_b = inst_b;
    e.o1 = o1; e.o2 = o2; e.bu1 = bu1; e.bu2 = bu2; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] data_a(input int i);
    case (i)
      2:       data_a = 32'h0055;
      3:       data_a = 32'hBEEF;
      5:       data_a = 32'h1234;
      7:       data_a = 32'hCAFE;
      default: data_a = 32'h0;
    endcase
  endfunction

  // Monitor: compare every expectation stamped for the current cycle.
  exp_t        m;
  logic [31:0] a1, a2;
  logic        ab1, ab2;
  logic [4:0]  ac;
  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_n) begin
      m = q.pop_front();
      checks++;
      if (m.inst_b) begin
        a1 = b_o1; a2 = b_o2; ab1 = b_busy1; ab2 = b_busy2; ac = b_cnt;
      end else begin
        a1 = {16'h0, SR1_Out}; a2 = {16'h0, SR2_Out};
        ab1 = Busy1; ab2 = Busy2; ac = {1'b0, Busy_Cnt};
      end
      if (m.cyc != cyc_n) begin
        errors++;
        $display("FAIL %s: expectation missed its cycle (stamped %0d, now %0d)", m.name, m.cyc, cyc_n);
      end else if (a1 !== m.o1 || a2 !== m.o2 || ab1 !== m.bu1 || ab2 !== m.bu2 || ac !== m.cnt) begin
        errors++;
        $display("FAIL %s cyc %0d: got o1=%h o2=%h b1=%b b2=%b cnt=%0d, want o1=%h o2=%h b1=%b b2=%b cnt=%0d",
                 m.name, cyc_n, a1, a2, ab1, ab2, ac, m.o1, m.o2, m.bu1, m.bu2, m.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with Load/Issue active: both must be ignored.
    Reset = 1'b1;
    Load = 1'b1; DR_In = 3'd1; In = 16'hFFFF; Issue = 1'b1; Issue_DR = 3'd1;
    SR1_In = '0; SR2_In = '0;
    b_load = 1'b1; b_dr = 4'd9; b_in = 32'hFFFF_FFFF; b_issue = 1'b1; b_idr = 4'd9;
    b_sr1 = '0; b_sr2 = '0;
    tick(); tick();
    Reset = 1'b0; Load = 1'b0; Issue = 1'b0; b_load = 1'b0; b_issue = 1'b0;

    for (int i = 0; i < 8; i++) begin
      SR1_In = 3'(i); SR2_In = 3'(7 - i);
      push("a_rst_rd", 1'b0, 0, 0, 0, 0, 0); tick();
    end
    for (int i = 0; i < 16; i++) begin
      b_sr1 = 4'(i); b_sr2 = 4'(15 - i);
      push("b_rst_rd", 1'b1, 0, 0, 0, 0, 0); tick();
    end

    // Writeback to a non-busy register; other registers untouched.
    Load = 1'b1; DR_In = 3'd3; In = 16'hBEEF; SR1_In = 3'd0; SR2_In = 3'd1;
    push("ld3_cur", 1'b0, 0, 0, 0, 0, 0); tick();
    Load = 1'b0; SR1_In = 3'd3; SR2_In = 3'd3;
    push("ld3_rd", 1'b0, 32'hBEEF, 32'hBEEF, 0, 0, 0); tick();
    SR1_In = 3'd0; SR2_In = 3'd1; push("ld3_oth01", 1'b0, 0, 0, 0, 0, 0); tick();
    SR1_In = 3'd2; SR2_In = 3'd4; push("ld3_oth24", 1'b0, 0, 0, 0, 0, 0); tick();
    SR1_In = 3'd5; SR2_In = 3'd6; push("ld3_oth56", 1'b0, 0, 0, 0, 0, 0); tick();
    SR1_In = 3'd7; SR2_In = 3'd7; push("ld3_oth77", 1'b0, 0, 0, 0, 0, 0); tick();

    // Issue R5, re-issue while busy, then writeback clears it.
    Issue = 1'b1; Issue_DR = 3'd5; SR1_In = 3'd0; SR2_In = 3'd5;
    push("iss5_cur", 1'b0, 0, 0, 0, 0, 0); tick();
    push("iss5_busy", 1'b0, 0, 0, 0, 1, 1); tick();
    Issue = 1'b0; Load = 1'b1; DR_In = 3'd5; In = 16'h1234; SR1_In = 3'd3;
    push("wb5_cur", 1'b0, 32'hBEEF, BYP ? 32'h1234 : 32'h0, 0, BYP ? 1'b0 : 1'b1, 1); tick();
    Load = 1'b0;
    push("wb5_rd", 1'b0, 32'hBEEF, 32'h1234, 0, 0, 0); tick();

    // Issue and Load to the same register: issue dominates.
    Issue = 1'b1; Issue_DR = 3'd2; Load = 1'b1; DR_In = 3'd2; In = 16'h00AA;
    SR1_In = 3'd2; SR2_In = 3'd2;
    push("same2_cur", 1'b0, BYP ? 32'hAA : 32'h0, BYP ? 32'hAA : 32'h0, BYP, BYP, 0); tick();
    Issue = 1'b0; Load = 1'b0;
    push("same2_rd", 1'b0, 32'hAA, 32'hAA, 1, 1, 1); tick();

    // Issue and Load to different registers.
    Issue = 1'b1; Issue_DR = 3'd4; Load = 1'b1; DR_In = 3'd2; In = 16'h0055;
    SR1_In = 3'd2; SR2_In = 3'd4;
    push("diff_cur", 1'b0, BYP ? 32'h55 : 32'hAA, 0, BYP ? 1'b0 : 1'b1, 0, 1); tick();
    Issue = 1'b0; Load = 1'b0;
    push("diff_rd", 1'b0, 32'h55, 0, 0, 1, 1); tick();

    // Read-during-write on R7.
    Load = 1'b1; DR_In = 3'd7; In = 16'hCAFE; SR1_In = 3'd7; SR2_In = 3'd7;
    push("rdw7_cur", 1'b0, BYP ? 32'hCAFE : 32'h0, BYP ? 32'hCAFE : 32'h0, 0, 0, 1); tick();
    Load = 1'b0;
    push("rdw7_rd", 1'b0, 32'hCAFE, 32'hCAFE, 0, 0, 1); tick();

    // Issue all eight (R4 already busy), count saturates at DEPTH.
    for (int i = 0; i < 8; i++) begin
      Issue = 1'b1; Issue_DR = 3'(i); SR1_In = 3'(i); SR2_In = 3'(i);
      push("iss_all", 1'b0, data_a(i), data_a(i), i == 4, i == 4, 5'(i <= 4 ? i + 1 : i)); tick();
    end
    Issue = 1'b0; SR1_In = 3'd0; SR2_In = 3'd7;
    push("all_busy", 1'b0, 0, 32'hCAFE, 1, 1, 8); tick();

    // Reset mid-operation with Load/Issue asserted.
    Reset = 1'b1; Load = 1'b1; DR_In = 3'd0; In = 16'hFFFF; Issue = 1'b1; Issue_DR = 3'd0;
    SR1_In = 3'd7; SR2_In = 3'd3;
    push("rst_pre", 1'b0, 32'hCAFE, 32'hBEEF, 1, 1, 8); tick();
    Reset = 1'b0; Load = 1'b0; Issue = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SR1_In = 3'(i); SR2_In = 3'(7 - i);
      push("a_post_rst", 1'b0, 0, 0, 0, 0, 0); tick();
    end

    // Wide instance: 32-bit data, fill all 16 busy bits.
    b_load = 1'b1; b_dr = 4'd9; b_in = 32'h89AB_CDEF; b_sr1 = 4'd8; b_sr2 = 4'd8;
    push("b_ld9_cur", 1'b1, 0, 0, 0, 0, 0); tick();
    b_load = 1'b0; b_sr1 = 4'd9;
    push("b_ld9_rd", 1'b1, 32'h89AB_CDEF, 0, 0, 0, 0); tick();
    for (int i = 0; i < 16; i++) begin
      b_issue = 1'b1; b_idr = 4'(i); b_sr1 = 4'(i); b_sr2 = 4'd9;
      push("b_iss", 1'b1, i == 9 ? 32'h89AB_CDEF : 32'h0, 32'h89AB_CDEF, 0, i > 9, 5'(i)); tick();
    end
    b_issue = 1'b0; b_sr1 = 4'd15; b_sr2 = 4'd0;
    push("b_full", 1'b1, 0, 0, 1, 1, 16); tick();
    Reset = 1'b1;
    push("b_rst_pre", 1'b1, 0, 0, 1, 1, 16); tick();
    Reset = 1'b0; b_sr1 = 4'd9; b_sr2 = 4'd15;
    push("b_post_rst", 1'b1, 0, 0, 0, 0, 0); tick();

    @(negedge Clk);
    #1;
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL drain: %0d expectations never compared, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
